// File: rtl/sdram_model_pkg.sv
// Shared types for the SDR SDRAM device model: command and error encodings, mode register fields.
package sdram_model_pkg;

  typedef enum logic [2:0] {
    CMD_NOP, CMD_ACT, CMD_READ, CMD_WRITE, CMD_PRE, CMD_REF, CMD_MRS, CMD_BST
  } cmd_t;

  typedef enum logic [3:0] {
    ERR_NONE     = 4'd0,
    ERR_ACT_OPEN = 4'd1,
    ERR_RW_IDLE  = 4'd2,
    ERR_TRCD     = 4'd3,
    ERR_TRP      = 4'd4,
    ERR_TRC      = 4'd5,
    ERR_MRS      = 4'd6,
    ERR_NO_MODE  = 4'd7,
    ERR_REF_OPEN = 4'd8,
    ERR_BAD_MODE = 4'd9,
    ERR_DQ       = 4'd10
  } err_t;

  typedef struct packed {
    logic [1:0] cl;      // CAS latency, 2 or 3
    logic [1:0] bl_log;  // burst length = 1 << bl_log
  } mode_t;

  typedef struct packed {
    mode_t mode;
    logic  ok;
  } mode_dec_t;

  function automatic mode_dec_t decode_mode(input logic [6:0] a);
    mode_dec_t r;
    r.mode.bl_log = a[1:0];
    r.mode.cl     = a[5:4];
    r.ok          = !a[2] && !a[3] && (a[6:4] == 3'b010 || a[6:4] == 3'b011);
    return r;
  endfunction

  // {cs,ras,cas,we} are active-low; a deselected or clock-disabled cycle is a NOP.
  function automatic cmd_t decode_cmd(input logic cke, input logic [3:0] c);
    cmd_t r;
    r = CMD_NOP;
    if (cke && !c[3]) begin
      case (c[2:0])
        3'b011:  r = CMD_ACT;
        3'b101:  r = CMD_READ;
        3'b100:  r = CMD_WRITE;
        3'b010:  r = CMD_PRE;
        3'b001:  r = CMD_REF;
        3'b000:  r = CMD_MRS;
        3'b110:  r = CMD_BST;
        default: r = CMD_NOP;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/sdram_model_bank.sv
// One SDRAM bank: IDLE/ACTIVE state, open row and tRCD/tRP/tRC down-counters.
// State and timers update on the clock edge after the accepted command; never stalls.
module sdram_model_bank
  import sdram_model_pkg::*;
#(
  parameter int ROW_BITS = 4,
  parameter int T_RCD    = 2,
  parameter int T_RP     = 2,
  parameter int T_RC     = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                act,
  input  logic                close,
  input  logic                refresh,
  input  logic [ROW_BITS-1:0] row_in,
  output logic                active,
  output logic [ROW_BITS-1:0] row,
  output logic                ok_act,
  output logic                ok_rw,
  output logic                rp_busy
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [0:0] state;
  logic [3:0] rcd_cnt, rp_cnt, rc_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      row     <= '0;
      rcd_cnt <= '0;
      rp_cnt  <= '0;
      rc_cnt  <= '0;
    end else begin
      if (rcd_cnt != '0) rcd_cnt <= rcd_cnt - 4'd1;
      if (rp_cnt != '0)  rp_cnt  <= rp_cnt - 4'd1;
      if (rc_cnt != '0)  rc_cnt  <= rc_cnt - 4'd1;
      // Counters load with T-1 so the command T cycles later sees zero.
      if (act) begin
        state   <= ACTIVE;
        row     <= row_in;
        rcd_cnt <= 4'(T_RCD - 1);
        rc_cnt  <= 4'(T_RC - 1);
      end else if (close && state == ACTIVE) begin
        state  <= IDLE;
        rp_cnt <= 4'(T_RP - 1);
      end
      if (refresh) rc_cnt <= 4'(T_RC - 1);
    end
  end

  assign active  = (state == ACTIVE);
  assign ok_act  = (rp_cnt == '0) && (rc_cnt == '0);
  assign ok_rw   = (rcd_cnt == '0);
  assign rp_busy = (rp_cnt != '0);

endmodule

// File: rtl/sdram_part_model.sv
// Cycle-accurate x16 SDR SDRAM part: command decode, burst engine, storage and protocol checker.
// Read beats appear CL cycles after issue; no backpressure, violations latch a sticky first error code.
module sdram_part_model
  import sdram_model_pkg::*;
#(
  parameter int ADDR_WIDTH    = 24,
  parameter int COL_WIDTH     = 9,
  parameter int ROW_WIDTH     = ADDR_WIDTH - COL_WIDTH - 3,
  parameter int ROW_IMPL_BITS = 4,
  parameter int T_RCD         = 2,
  parameter int T_RP          = 2,
  parameter int T_RC          = 7,
  parameter int T_MRD         = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cke,
  input  logic                 cs,
  input  logic                 ras,
  input  logic                 cas,
  input  logic                 we,
  input  logic [1:0]           dqm,
  input  logic [ROW_WIDTH-1:0] addr,
  input  logic [1:0]           ba,
  input  logic [15:0]          write_data,
  input  logic                 wr_en,
  output logic [15:0]          read_data,
  output logic                 dq_oe,
  output logic                 protocol_err,
  output logic [3:0]           err_code
);

  localparam int MEM_AW = 2 + ROW_IMPL_BITS + COL_WIDTH;

  logic [15:0] mem [0:(1 << MEM_AW) - 1];

  cmd_t      cmd;
  mode_dec_t mrs_dec;
  mode_t     mode;
  logic      mode_vld;
  logic [3:0] mrd_cnt;

  logic [3:0] b_active, b_ok_act, b_ok_rw, b_rp_busy, ap_close;
  logic [ROW_IMPL_BITS-1:0] b_row [4];

  logic acc_act, acc_rw, acc_pre, acc_ref, acc_mrs, acc_bst;
  logic [9:1]  cmd_err;
  logic [10:1] err_vec;
  err_t        err_now;

  logic                     bst_on, bst_rd, bst_ap;
  logic [1:0]               bst_ba;
  logic [ROW_IMPL_BITS-1:0] bst_row;
  logic [COL_WIDTH-1:0]     bst_col;
  logic [2:0]               bst_k;

  logic                     beat_vld, beat_rd, beat_ap, beat_last;
  logic [1:0]               beat_ba;
  logic [ROW_IMPL_BITS-1:0] beat_row;
  logic [COL_WIDTH-1:0]     beat_col, beat_col_k;
  logic [2:0]               beat_k, bl_mask, wrap_lo;
  logic [MEM_AW-1:0]        beat_idx;

  logic [2:0]  pipe_vld;
  logic [15:0] pipe_dat [3];
  logic [1:0]  dqm_d1, dqm_d2;
  logic        slot_vld;
  logic [15:0] slot_dat;

  assign cmd     = decode_cmd(cke, {cs, ras, cas, we});
  assign mrs_dec = decode_mode(addr[6:0]);

  for (genvar g = 0; g < 4; g++) begin : g_bank
    sdram_model_bank #(
      .ROW_BITS(ROW_IMPL_BITS), .T_RCD(T_RCD), .T_RP(T_RP), .T_RC(T_RC)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .act     (acc_act && ba == 2'(g)),
      .close   ((acc_pre && (addr[10] || ba == 2'(g))) || ap_close[g]),
      .refresh (acc_ref),
      .row_in  (addr[ROW_IMPL_BITS-1:0]),
      .active  (b_active[g]),
      .row     (b_row[g]),
      .ok_act  (b_ok_act[g]),
      .ok_rw   (b_ok_rw[g]),
      .rp_busy (b_rp_busy[g])
    );
  end

  // Any flagged command is rejected; a RD/WR without a mode reports only the missing mode.
  always_comb begin
    cmd_err = '0;
    acc_act = 1'b0;
    acc_rw  = 1'b0;
    acc_pre = 1'b0;
    acc_ref = 1'b0;
    acc_mrs = 1'b0;
    acc_bst = 1'b0;
    if (cmd != CMD_NOP && mrd_cnt != '0) begin
      cmd_err[ERR_MRS] = 1'b1;
    end else begin
      case (cmd)
        CMD_ACT: begin
          if (b_active[ba]) cmd_err[ERR_ACT_OPEN] = 1'b1;
          if (b_rp_busy[ba]) cmd_err[ERR_TRP] = 1'b1;
          else if (!b_ok_act[ba]) cmd_err[ERR_TRC] = 1'b1;
          acc_act = !b_active[ba] && b_ok_act[ba];
        end
        CMD_READ, CMD_WRITE: begin
          if (!mode_vld) cmd_err[ERR_NO_MODE] = 1'b1;
          else if (!b_active[ba]) cmd_err[ERR_RW_IDLE] = 1'b1;
          else if (!b_ok_rw[ba]) cmd_err[ERR_TRCD] = 1'b1;
          else acc_rw = 1'b1;
        end
        CMD_PRE: acc_pre = 1'b1;
        CMD_REF: begin
          if (|b_active) cmd_err[ERR_REF_OPEN] = 1'b1;
          if (|b_rp_busy) cmd_err[ERR_TRP] = 1'b1;
          else if (!(&b_ok_act)) cmd_err[ERR_TRC] = 1'b1;
          acc_ref = !(|b_active) && (&b_ok_act);
        end
        CMD_MRS: begin
          if (|b_active) cmd_err[ERR_MRS] = 1'b1;
          if (!mrs_dec.ok) cmd_err[ERR_BAD_MODE] = 1'b1;
          acc_mrs = !(|b_active) && mrs_dec.ok;
        end
        CMD_BST: acc_bst = 1'b1;
        default: ;
      endcase
    end
  end

  assign bl_mask = 3'((4'd1 << mode.bl_log) - 4'd1);

  always_comb begin
    beat_vld = 1'b0;
    beat_rd  = bst_rd;
    beat_ba  = bst_ba;
    beat_row = bst_row;
    beat_col = bst_col;
    beat_k   = bst_k;
    beat_ap  = bst_ap;
    if (acc_rw) begin
      beat_vld = 1'b1;
      beat_rd  = (cmd == CMD_READ);
      beat_ba  = ba;
      beat_row = b_row[ba];
      beat_col = addr[COL_WIDTH-1:0];
      beat_k   = 3'd0;
      beat_ap  = addr[10];
    end else if (bst_on && !acc_bst) begin
      beat_vld = 1'b1;
    end
  end

  // Column wraps inside the BL-aligned block.
  assign wrap_lo    = ((beat_col[2:0] + beat_k) & bl_mask) | (beat_col[2:0] & ~bl_mask);
  assign beat_col_k = {beat_col[COL_WIDTH-1:3], wrap_lo};
  assign beat_idx   = {beat_ba, beat_row, beat_col_k};
  assign beat_last  = (beat_k == bl_mask);

  for (genvar g = 0; g < 4; g++) begin : g_ap
    assign ap_close[g] = beat_vld && beat_last && beat_ap && beat_ba == 2'(g);
  end

  assign err_vec = {(wr_en && dq_oe) || (beat_vld && !beat_rd && !wr_en), cmd_err};

  always_comb begin
    err_now = ERR_NONE;
    for (int i = 10; i >= 1; i--) begin
      if (err_vec[i]) err_now = err_t'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode         <= '0;
      mode_vld     <= 1'b0;
      mrd_cnt      <= '0;
      bst_on       <= 1'b0;
      bst_rd       <= 1'b0;
      bst_ap       <= 1'b0;
      bst_ba       <= '0;
      bst_row      <= '0;
      bst_col      <= '0;
      bst_k        <= '0;
      pipe_vld     <= '0;
      pipe_dat     <= '{default: '0};
      dqm_d1       <= '0;
      dqm_d2       <= '0;
      protocol_err <= 1'b0;
      err_code     <= '0;
    end else begin
      if (mrd_cnt != '0) mrd_cnt <= mrd_cnt - 4'd1;
      if (acc_mrs) begin
        mode     <= mrs_dec.mode;
        mode_vld <= 1'b1;
        mrd_cnt  <= 4'(T_MRD - 1);
      end
      bst_on <= beat_vld && !beat_last;
      bst_k  <= beat_k + 3'd1;
      if (acc_rw) begin
        bst_rd  <= beat_rd;
        bst_ap  <= beat_ap;
        bst_ba  <= beat_ba;
        bst_row <= beat_row;
        bst_col <= beat_col;
      end
      pipe_vld    <= {pipe_vld[1:0], beat_vld && beat_rd};
      pipe_dat[0] <= mem[beat_idx];
      pipe_dat[1] <= pipe_dat[0];
      pipe_dat[2] <= pipe_dat[1];
      dqm_d1      <= dqm;
      dqm_d2      <= dqm_d1;
      if (!protocol_err && err_now != ERR_NONE) begin
        protocol_err <= 1'b1;
        err_code     <= err_now;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && beat_vld && !beat_rd && wr_en) begin
      if (!dqm[0]) mem[beat_idx][7:0]  <= write_data[7:0];
      if (!dqm[1]) mem[beat_idx][15:8] <= write_data[15:8];
    end
  end

  assign slot_vld  = (mode.cl == 2'd3) ? pipe_vld[2] : pipe_vld[1];
  assign slot_dat  = (mode.cl == 2'd3) ? pipe_dat[2] : pipe_dat[1];
  assign dq_oe     = slot_vld && !(&dqm_d2);
  assign read_data = slot_vld ? {dqm_d2[1] ? 8'h00 : slot_dat[15:8],
                                 dqm_d2[0] ? 8'h00 : slot_dat[7:0]} : 16'h0000;

endmodule
